// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared video timing constants for the 800x600@72Hz display path.
//   Imported by the timing generator, the position controller and the
//   renderer so that all of them agree on coordinate width and frame geometry.
package vga_pkg;

    localparam int COORD_W = 11;

    localparam int H_VIS_DEF  = 800;
    localparam int H_FP_DEF   = 56;
    localparam int H_SYNC_DEF = 120;
    localparam int H_BP_DEF   = 64;

    localparam int V_VIS_DEF  = 600;
    localparam int V_FP_DEF   = 37;
    localparam int V_SYNC_DEF = 6;
    localparam int V_BP_DEF   = 23;

    localparam int H_TOTAL_DEF = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 1040
    localparam int V_TOTAL_DEF = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 666

endpackage

// File: rtl/vga_timing_counter.sv
// timing_counter
//   Mod-N up counter with enable. wrap_o is high during the enabled cycle in
//   which the count sits at N-1, i.e. the cycle that returns it to 0, so it
//   can directly enable a cascaded counter.
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset (count -> 0)
//   en_i     in   advance enable
//   cnt_o    out  current count, 0..N-1
//   wrap_o   out  count is N-1 and en_i is high
module timing_counter
    import vga_pkg::*;
#(
    parameter int N = H_TOTAL_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en_i,
    output logic [COORD_W-1:0] cnt_o,
    output logic               wrap_o
);

    localparam logic [COORD_W-1:0] LAST = COORD_W'(N - 1);

    logic [COORD_W-1:0] cnt_q;
    logic [COORD_W-1:0] cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        wrap_o = 1'b0;
        if (en_i) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                wrap_o = 1'b1;
            end else begin
                cnt_d = cnt_q + COORD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/vga_timing.sv
// vga_timing
//   Video timing generator: horizontal/vertical counters, sync and active
//   video decode, frame markers and frame counter. Every output comes from a
//   single register stage fed by the counters, so all outputs in a given cycle
//   describe the same (x,y).
// Ports:
//   clk        in   pixel clock
//   reset_n    in   asynchronous active-low reset
//   x, y       out  registered pixel column / line
//   de         out  active video
//   hsync      out  horizontal sync, active level HS_POL
//   vsync      out  vertical sync, active level VS_POL
//   SOF        out  pulse on the last cycle of the frame (before pixel 0,0)
//   EOF        out  pulse on the first cycle after the last visible pixel
//   frame_cnt  out  frame counter, wraps 255 -> 0
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VIS  = H_VIS_DEF,
    parameter int H_FP   = H_FP_DEF,
    parameter int H_SYNC = H_SYNC_DEF,
    parameter int H_BP   = H_BP_DEF,
    parameter int V_VIS  = V_VIS_DEF,
    parameter int V_FP   = V_FP_DEF,
    parameter int V_SYNC = V_SYNC_DEF,
    parameter int V_BP   = V_BP_DEF,
    parameter bit HS_POL = 1'b1,
    parameter bit VS_POL = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               de,
    output logic               hsync,
    output logic               vsync,
    output logic               SOF,
    output logic               EOF,
    output logic [7:0]         frame_cnt
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_VIS_C  = COORD_W'(H_VIS);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VIS + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] V_VIS_C  = COORD_W'(V_VIS);
    localparam logic [COORD_W-1:0] V_LASTV  = COORD_W'(V_VIS - 1);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VIS + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VIS + V_FP + V_SYNC);

    logic [COORD_W-1:0] hcnt;
    logic [COORD_W-1:0] vcnt;
    logic               hwrap;
    logic               vwrap;

    timing_counter #(.N(H_TOTAL)) u_hcnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (1'b1),
        .cnt_o   (hcnt),
        .wrap_o  (hwrap)
    );

    timing_counter #(.N(V_TOTAL)) u_vcnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (hwrap),
        .cnt_o   (vcnt),
        .wrap_o  (vwrap)
    );

    // Frame counter lives alongside the pixel counters; it is copied through
    // the output stage below so it changes together with x,y returning to 0,0.
    logic [7:0] frm_q;
    logic [7:0] frm_d;

    always_comb begin
        frm_d = frm_q;
        if (vwrap) begin
            frm_d = frm_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frm_q <= '0;
        end else begin
            frm_q <= frm_d;
        end
    end

    logic de_d, hs_d, vs_d, sof_d, eof_d;

    always_comb begin
        de_d  = (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
        hs_d  = ((hcnt >= HS_START) && (hcnt < HS_END)) ? HS_POL : ~HS_POL;
        vs_d  = ((vcnt >= VS_START) && (vcnt < VS_END)) ? VS_POL : ~VS_POL;
        // vwrap is only high on the last pixel of the last line.
        sof_d = vwrap;
        eof_d = (hcnt == H_VIS_C) && (vcnt == V_LASTV);
    end

    logic [COORD_W-1:0] x_q, y_q;
    logic               de_q, hs_q, vs_q, sof_q, eof_q;
    logic [7:0]         frame_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q     <= '0;
            y_q     <= '0;
            de_q    <= 1'b0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            frame_q <= '0;
        end else begin
            x_q     <= hcnt;
            y_q     <= vcnt;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            frame_q <= frm_q;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign de        = de_q;
    assign hsync     = hs_q;
    assign vsync     = vs_q;
    assign SOF       = sof_q;
    assign EOF       = eof_q;
    assign frame_cnt = frame_q;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing
//   Bench for vga_timing using a reduced geometry (16 x 8 total, 8 x 4
//   visible) so that full frames and the 256-frame wrap fit in a short run.
//   Two instances share clock and reset: u0 with active-high syncs, u1 with
//   active-low syncs.
module tb_vga_timing;

    // Reduced geometry:
    //   H: vis 8, fp 2, sync 3, bp 3  -> total 16, hsync x = 10..12
    //   V: vis 4, fp 1, sync 2, bp 1  -> total 8,  vsync y = 5..6
    //   frame = 128 cycles, EOF at (8,3), SOF at (15,7)
    localparam int FT = 128;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    logic [10:0] x0, y0, x1, y1;
    logic        de0, hs0, vs0, sof0, eof0;
    logic        de1, hs1, vs1, sof1, eof1;
    logic [7:0]  fc0, fc1;

    vga_timing #(
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u0 (
        .clk(clk), .reset_n(reset_n), .x(x0), .y(y0), .de(de0),
        .hsync(hs0), .vsync(vs0), .SOF(sof0), .EOF(eof0), .frame_cnt(fc0)
    );

    vga_timing #(
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u1 (
        .clk(clk), .reset_n(reset_n), .x(x1), .y(y1), .de(de1),
        .hsync(hs1), .vsync(vs1), .SOF(sof1), .EOF(eof1), .frame_cnt(fc1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Expected output bundle for the k-th sampled cycle after reset release.
    function automatic logic [63:0] exp_vec(input int k, input bit pol);
        int p, h, v, f;
        logic de_e, hs_e, vs_e, sof_e, eof_e;
        p     = k % FT;
        h     = p % 16;
        v     = p / 16;
        f     = (k / FT) % 256;
        de_e  = (h < 8) && (v < 4);
        hs_e  = (h >= 10) && (h <= 12);
        vs_e  = (v >= 5) && (v <= 6);
        sof_e = (h == 15) && (v == 7);
        eof_e = (h == 8) && (v == 3);
        if (!pol) begin
            hs_e = ~hs_e;
            vs_e = ~vs_e;
        end
        return {27'd0, f[7:0], h[10:0], v[10:0], de_e, hs_e, vs_e, sof_e, eof_e};
    endfunction

    function automatic logic [63:0] obs0();
        return {27'd0, fc0, x0, y0, de0, hs0, vs0, sof0, eof0};
    endfunction

    function automatic logic [63:0] obs1();
        return {27'd0, fc1, x1, y1, de1, hs1, vs1, sof1, eof1};
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_u0"}, obs0(), {27'd0, 8'd0, 11'd0, 11'd0, 5'b00000});
        check({tag, "_u1"}, obs1(), {27'd0, 8'd0, 11'd0, 11'd0, 5'b01100});
    endtask

    int de_cnt, hs_rises, hs_run, hs_run_min, hs_run_max, hs_rise_x;
    int vs_run, vs_runs, vs_rise_x, vs_rise_y;
    int sof_cnt, eof_cnt, k_sof, k_eof, gap_se, gap_es, de_blank;
    int line_gap, k_line;
    bit hs_prev, vs_prev, in_blank;

    initial begin
        de_cnt = 0; hs_rises = 0; hs_run = 0; hs_run_min = 9999; hs_run_max = 0;
        hs_rise_x = -1; vs_run = 0; vs_runs = 0; vs_rise_x = -1; vs_rise_y = -1;
        sof_cnt = 0; eof_cnt = 0; k_sof = -1; k_eof = -1; gap_se = 0; gap_es = 0;
        de_blank = 0; line_gap = 0; k_line = -1;
        hs_prev = 0; vs_prev = 0; in_blank = 0;

        // Reset held for 5 cycles; outputs sit at their reset values.
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_vals("reset");
        reset_n = 1'b1;

        // Two full frames, every output compared every cycle, plus line/frame
        // measurements taken from the observed waveforms.
        for (int k = 0; k < 2 * FT; k++) begin
            @(negedge clk);
            check("frame_u0", obs0(), exp_vec(k, 1'b1));
            check("frame_u1", obs1(), exp_vec(k, 1'b0));
            if (de0) de_cnt++;
            if (x0 == 11'd0) begin
                if (k_line >= 0) line_gap = k - k_line;
                k_line = k;
            end
            if (hs0 && !hs_prev) begin
                hs_rises++;
                hs_run = 1;
                if (hs_rise_x < 0) hs_rise_x = int'(x0);
            end else if (hs0) begin
                hs_run++;
            end else if (hs_prev) begin
                if (hs_run < hs_run_min) hs_run_min = hs_run;
                if (hs_run > hs_run_max) hs_run_max = hs_run;
            end
            if (vs0 && !vs_prev) begin
                vs_runs++;
                vs_run = 1;
                if (vs_rise_y < 0) begin
                    vs_rise_x = int'(x0);
                    vs_rise_y = int'(y0);
                end
            end else if (vs0) begin
                vs_run++;
            end
            if (in_blank && de0) de_blank++;
            if (eof0) begin
                eof_cnt++;
                if (k_sof >= 0) gap_se = k - k_sof;
                k_eof = k;
                in_blank = 1;
            end
            if (sof0) begin
                sof_cnt++;
                if (k_eof >= 0) gap_es = k - k_eof;
                k_sof = k;
                in_blank = 0;
            end
            hs_prev = hs0;
            vs_prev = vs0;
        end

        check("de_per_2frames",   64'(de_cnt),     64'd64);
        check("line_period",      64'(line_gap),   64'd16);
        check("hs_rises",         64'(hs_rises),   64'd16);
        check("hs_width_min",     64'(hs_run_min), 64'd3);
        check("hs_width_max",     64'(hs_run_max), 64'd3);
        check("hs_start_x",       64'(hs_rise_x),  64'd10);
        check("vs_runs",          64'(vs_runs),    64'd2);
        check("vs_width",         64'(vs_run),     64'd32);
        check("vs_start_x",       64'(vs_rise_x),  64'd0);
        check("vs_start_y",       64'(vs_rise_y),  64'd5);
        check("sof_count",        64'(sof_cnt),    64'd2);
        check("eof_count",        64'(eof_cnt),    64'd2);
        check("sof_to_eof",       64'(gap_se),     64'd57);
        check("eof_to_sof",       64'(gap_es),     64'd71);
        check("de_in_vblank",     64'(de_blank),   64'd0);

        // Continue into frame 2 up to pixel (4,2), then pulse reset there.
        for (int k = 2 * FT; k <= 2 * FT + 36; k++) begin
            @(negedge clk);
            check("pre_rst_u0", obs0(), exp_vec(k, 1'b1));
        end
        reset_n = 1'b0;
        #1;
        check_reset_vals("midrst_async");
        @(negedge clk);
        check_reset_vals("midrst_hold");
        reset_n = 1'b1;

        // Timing restarts at (0,0) with frame_cnt=0.
        for (int k = 0; k < FT; k++) begin
            @(negedge clk);
            check("restart_u0", obs0(), exp_vec(k, 1'b1));
            check("restart_u1", obs1(), exp_vec(k, 1'b0));
        end

        // Frame counter wrap after 256 frames.
        for (int k = FT; k <= 256 * FT; k++) begin
            @(negedge clk);
            if (k == FT || k == 255 * FT || k == 256 * FT - 1 || k == 256 * FT) begin
                check("wrap_u0", obs0(), exp_vec(k, 1'b1));
                check("wrap_u1", obs1(), exp_vec(k, 1'b0));
            end
        end
        check("frame_cnt_wrapped", 64'(fc0), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
